// File: rtl/mem_wb_stage.sv
// mem_wb_stage: pipeline register between the MEM stage and the writeback
// data-source mux. Registers the MEM-stage control and data fields, lines up
// the synchronous data-memory read data with the load that owns it (holding
// it stable while the pipeline is stalled) and counts retired instructions.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, adds bypass_valid / bypass_reg / bypass_data, which present
//   the final writeback value to EX-stage forwarding. When undefined, those
//   ports and their logic are absent.

module mem_wb_stage #(
    parameter int DW     = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_MEM,
    input  logic              LW_MEM,
    input  logic              ADDI_MEM,
    input  logic              SUBI_MEM,
    input  logic              MOVI_MEM,
    input  logic              WRE_MEM,
    input  logic [REG_AW-1:0] WReg1_MEM,
    input  logic [DW-1:0]     ALU_out_MEM,
    input  logic [DW-1:0]     Offset_MEM,
    input  logic [DW-1:0]     D_out_mem,
    output logic              valid_WB,
    output logic              LW_WB,
    output logic              ADDI_WB,
    output logic              SUBI_WB,
    output logic              MOVI_WB,
    output logic              WRE_WB,
    output logic [REG_AW-1:0] WReg1_WB,
    output logic [DW-1:0]     ALU_out_WB,
    output logic [DW-1:0]     Offset_WB,
    output logic [DW-1:0]     D_out_WB,
    output logic [CNT_W-1:0]  retire_count
`ifdef WB_BYPASS_EN
    ,
    output logic              bypass_valid,
    output logic [REG_AW-1:0] bypass_reg,
    output logic [DW-1:0]     bypass_data
`endif
);

    // Raw registered write enable; the visible WRE_WB is qualified by valid_WB
    // so a bubble can never write the register file.
    logic              wre_q;

    // Load data captured on the first stall edge of a load sitting in WB,
    // because the memory read port is free to change while we are stalled.
    logic              hold_valid;
    logic [DW-1:0]     hold_reg;

    // A qualifying stall edge: a real load in WB whose data is not yet held.
    logic              capture_load;
    assign capture_load = valid_WB & LW_WB & ~hold_valid;

    // Control fields: cleared by reset, squashed by flush, frozen by stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_WB <= 1'b0;
            LW_WB    <= 1'b0;
            ADDI_WB  <= 1'b0;
            SUBI_WB  <= 1'b0;
            MOVI_WB  <= 1'b0;
            wre_q    <= 1'b0;
        end else if (flush) begin
            valid_WB <= 1'b0;
            LW_WB    <= 1'b0;
            ADDI_WB  <= 1'b0;
            SUBI_WB  <= 1'b0;
            MOVI_WB  <= 1'b0;
            wre_q    <= 1'b0;
        end else if (!stall) begin
            valid_WB <= valid_MEM;
            LW_WB    <= LW_MEM;
            ADDI_WB  <= ADDI_MEM;
            SUBI_WB  <= SUBI_MEM;
            MOVI_WB  <= MOVI_MEM;
            wre_q    <= WRE_MEM;
        end
    end

    // Data fields: cleared by reset, otherwise only move on a normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            WReg1_WB   <= '0;
            ALU_out_WB <= '0;
            Offset_WB  <= '0;
        end else if (!flush && !stall) begin
            WReg1_WB   <= WReg1_MEM;
            ALU_out_WB <= ALU_out_MEM;
            Offset_WB  <= Offset_MEM;
        end
    end

    // Load-data hold: capture once per stall run, release when the pipe moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_reg   <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (stall) begin
            if (capture_load) begin
                hold_valid <= 1'b1;
                hold_reg   <= D_out_mem;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    // Retired-instruction counter: counts the real instruction leaving WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= '0;
        end else if (!flush && !stall && valid_WB) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

    // Output qualification and load-data selection.
    always_comb begin
        WRE_WB   = wre_q & valid_WB;
        D_out_WB = hold_valid ? hold_reg : D_out_mem;
    end

`ifdef WB_BYPASS_EN
    // Final writeback value for forwarding, in the writeback mux priority.
    always_comb begin
        bypass_valid = WRE_WB;
        bypass_reg   = WReg1_WB;
        bypass_data  = D_out_WB;
        if (!LW_WB && (ADDI_WB || SUBI_WB)) begin
            bypass_data = ALU_out_WB;
        end else if (MOVI_WB && !LW_WB && !ADDI_WB) begin
            bypass_data = Offset_WB;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage (CNT_W=4 so the
// retired-instruction counter wrap is reachable). Each applied cycle pushes
// the expected WB state onto a queue; it is popped and compared after the edge.

module tb_mem_wb_stage;

    localparam int DW     = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              valid_MEM;
    logic              LW_MEM;
    logic              ADDI_MEM;
    logic              SUBI_MEM;
    logic              MOVI_MEM;
    logic              WRE_MEM;
    logic [REG_AW-1:0] WReg1_MEM;
    logic [DW-1:0]     ALU_out_MEM;
    logic [DW-1:0]     Offset_MEM;
    logic [DW-1:0]     D_out_mem;
    logic              valid_WB;
    logic              LW_WB;
    logic              ADDI_WB;
    logic              SUBI_WB;
    logic              MOVI_WB;
    logic              WRE_WB;
    logic [REG_AW-1:0] WReg1_WB;
    logic [DW-1:0]     ALU_out_WB;
    logic [DW-1:0]     Offset_WB;
    logic [DW-1:0]     D_out_WB;
    logic [CNT_W-1:0]  retire_count;
`ifdef WB_BYPASS_EN
    logic              bypass_valid;
    logic [REG_AW-1:0] bypass_reg;
    logic [DW-1:0]     bypass_data;
`endif

    mem_wb_stage #(.DW(DW), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .valid_MEM    (valid_MEM),
        .LW_MEM       (LW_MEM),
        .ADDI_MEM     (ADDI_MEM),
        .SUBI_MEM     (SUBI_MEM),
        .MOVI_MEM     (MOVI_MEM),
        .WRE_MEM      (WRE_MEM),
        .WReg1_MEM    (WReg1_MEM),
        .ALU_out_MEM  (ALU_out_MEM),
        .Offset_MEM   (Offset_MEM),
        .D_out_mem    (D_out_mem),
        .valid_WB     (valid_WB),
        .LW_WB        (LW_WB),
        .ADDI_WB      (ADDI_WB),
        .SUBI_WB      (SUBI_WB),
        .MOVI_WB      (MOVI_WB),
        .WRE_WB       (WRE_WB),
        .WReg1_WB     (WReg1_WB),
        .ALU_out_WB   (ALU_out_WB),
        .Offset_WB    (Offset_WB),
        .D_out_WB     (D_out_WB),
        .retire_count (retire_count)
`ifdef WB_BYPASS_EN
        ,
        .bypass_valid (bypass_valid),
        .bypass_reg   (bypass_reg),
        .bypass_data  (bypass_data)
`endif
    );

    // Reference WB-stage state, built from the behavioural description.
    typedef struct packed {
        logic              valid;
        logic              lw;
        logic              addi;
        logic              subi;
        logic              movi;
        logic              wre;
        logic [REG_AW-1:0] wreg;
        logic [DW-1:0]     alu;
        logic [DW-1:0]     off;
        logic [CNT_W-1:0]  cnt;
        logic              hv;
        logic [DW-1:0]     hold;
    } wb_t;

    wb_t  model;
    wb_t  exp_q[$];
    logic model_known;
    int   checks;
    int   failures;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, compare.
    task automatic applyStimulus(input logic rst, input logic stl, input logic fls,
                                 input logic v, input logic lw, input logic addi,
                                 input logic subi, input logic movi, input logic wre,
                                 input logic [REG_AW-1:0] wreg, input logic [DW-1:0] alu,
                                 input logic [DW-1:0] off, input logic [DW-1:0] dmem);
        wb_t n;
        wb_t e;
        logic [DW-1:0] exp_dout;
        logic [DW-1:0] exp_byp;
        reset = rst; stall = stl; flush = fls;
        valid_MEM = v; LW_MEM = lw; ADDI_MEM = addi; SUBI_MEM = subi; MOVI_MEM = movi;
        WRE_MEM = wre; WReg1_MEM = wreg; ALU_out_MEM = alu; Offset_MEM = off;
        D_out_mem = dmem;
        #1;
        if (model_known) begin
            checkOutput("D_out_WB_comb", D_out_WB, model.hv ? model.hold : dmem);
        end
        n = model;
        if (rst) begin
            n = '0;
        end else if (fls) begin
            n.valid = 1'b0; n.lw = 1'b0; n.addi = 1'b0; n.subi = 1'b0;
            n.movi = 1'b0; n.wre = 1'b0; n.hv = 1'b0;
        end else if (stl) begin
            if (model.valid && model.lw && !model.hv) begin
                n.hv = 1'b1;
                n.hold = dmem;
            end
        end else begin
            n.valid = v; n.lw = lw; n.addi = addi; n.subi = subi; n.movi = movi;
            n.wre = wre; n.wreg = wreg; n.alu = alu; n.off = off; n.hv = 1'b0;
            if (model.valid) n.cnt = model.cnt + 1'b1;
        end
        if (rst) model_known = 1'b1;
        model = n;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        exp_dout = e.hv ? e.hold : dmem;
        checkOutput("valid_WB", valid_WB, e.valid);
        checkOutput("LW_WB", LW_WB, e.lw);
        checkOutput("ADDI_WB", ADDI_WB, e.addi);
        checkOutput("SUBI_WB", SUBI_WB, e.subi);
        checkOutput("MOVI_WB", MOVI_WB, e.movi);
        checkOutput("WRE_WB", WRE_WB, e.wre & e.valid);
        checkOutput("retire_count", retire_count, e.cnt);
        checkOutput("D_out_WB", D_out_WB, exp_dout);
        if (e.valid || rst) begin
            checkOutput("WReg1_WB", WReg1_WB, e.wreg);
            checkOutput("ALU_out_WB", ALU_out_WB, e.alu);
            checkOutput("Offset_WB", Offset_WB, e.off);
        end
        if (!e.lw && (e.addi || e.subi)) exp_byp = e.alu;
        else if (e.movi && !e.lw && !e.addi) exp_byp = e.off;
        else exp_byp = exp_dout;
`ifdef WB_BYPASS_EN
        checkOutput("bypass_valid", bypass_valid, e.wre & e.valid);
        checkOutput("bypass_reg", bypass_reg, e.wreg);
        checkOutput("bypass_data", bypass_data, exp_byp);
`else
        if (exp_byp === 'x) $display("[TB] unexpected X in bypass model");
`endif
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model = '0;
        model_known = 1'b0;

        $display("[TB] reset with nonzero inputs");
        applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 1, 5'd9, 64'hAA, 64'hBB, 64'hCC);
        applyStimulus(1, 1, 0, 1, 1, 0, 0, 0, 1, 5'd9, 64'hAA, 64'hBB, 64'hCC);
        checkOutput("tp_reset_count", retire_count, 0);
        checkOutput("tp_reset_valid", valid_WB, 0);

        $display("[TB] first ADDI after reset");
        applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 1, 5'd3, 64'h5, 64'h1, 64'h0);
        checkOutput("tp_addi_alu", ALU_out_WB, 64'h5);
        checkOutput("tp_addi_flag", ADDI_WB, 1);

        $display("[TB] load alignment and stall on load");
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 1, 5'd7, 64'h100, 64'h0, 64'h0);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 1, 1, 5'd4, 64'h0, 64'h9, 64'hDEADBEEF);
        checkOutput("tp_lw_dout", D_out_WB, 64'hDEADBEEF);
        checkOutput("tp_lw_dest", WReg1_WB, 7);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 1, 1, 5'd4, 64'h0, 64'h9, 64'h1234);
        checkOutput("tp_stall_hold", D_out_WB, 64'hDEADBEEF);
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 1, 1, 5'd4, 64'h0, 64'h9, 64'h1234);
        checkOutput("tp_stall_count", retire_count, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1, 5'd4, 64'h0, 64'h9, 64'h1234);
        checkOutput("tp_release_count", retire_count, 2);

        $display("[TB] flush with stall, valid MOVI in MEM");
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 1, 1, 5'd6, 64'h0, 64'h9, 64'h55);
        checkOutput("tp_flush_valid", valid_WB, 0);
        checkOutput("tp_flush_count", retire_count, 2);

        $display("[TB] flush clears held load data");
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 1, 5'd8, 64'h200, 64'h0, 64'h0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'hAAAA);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'hBBBB);
        checkOutput("tp_flush_hold", D_out_WB, 64'hBBBB);

        $display("[TB] SUBI / MOVI / bubble writeback selection");
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 1, 5'd2, 64'h7, 64'h9, 64'h3);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1, 5'd2, 64'h7, 64'h9, 64'h3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd2, 64'h7, 64'h9, 64'h3);
        checkOutput("tp_bubble_wre", WRE_WB, 0);

        $display("[TB] counter wrap");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 1, 5'(i), 64'(i), 64'h0, 64'h0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0);
        checkOutput("tp_wrap_count", retire_count, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            int op;
            logic [DW-1:0] a, o, d;
            op = $urandom_range(0, 4);
            a = {$urandom, $urandom};
            o = {$urandom, $urandom};
            d = {$urandom, $urandom};
            applyStimulus(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                          (op != 0), (op == 1), (op == 2), (op == 3), (op == 4),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), a, o, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage and the writeback data-source mux.
- Captures the ALU result, the immediate offset, the opcode flags, and the destination register/write-enable from MEM.
- Aligns synchronous data-memory read data, which arrives one cycle after the address, with its instruction. Holds that data stable across stalls.
- Keeps a retired-instruction counter for debug.

Parameters:
DW, 64, datapath width (ALU_out, Offset, D_out)
REG_AW, 5, register-file address width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold all WB-stage registers this cycle
flush  in  1  squash the instruction entering WB (insert bubble)
valid_MEM  in  1  MEM stage holds a real instruction
LW_MEM  in  1  load opcode flag
ADDI_MEM  in  1  add-immediate flag
SUBI_MEM  in  1  subtract-immediate flag
MOVI_MEM  in  1  move-immediate flag
WRE_MEM  in  1  register-file write enable
WReg1_MEM  in  REG_AW  destination register
ALU_out_MEM  in  DW  ALU result
Offset_MEM  in  DW  sign-extended immediate
D_out_mem  in  DW  data-memory read port (valid the cycle after MEM)
valid_WB  out  1  WB holds a real instruction
LW_WB, ADDI_WB, SUBI_WB, MOVI_WB  out  1 each  registered opcode flags
WRE_WB  out  1  registered write enable, forced 0 when valid_WB=0
WReg1_WB  out  REG_AW  registered destination
ALU_out_WB  out  DW  registered ALU result
Offset_WB  out  DW  registered immediate
D_out_WB  out  DW  load data aligned to the WB instruction
retire_count  out  CNT_W  instructions retired since reset

Behaviour:
- Reset (sync, priority over everything):
  - All registered outputs go to 0, including valid_WB, the flags, WRE_WB, WReg1_WB, ALU_out_WB, Offset_WB and retire_count.
  - hold_valid is cleared, so D_out_WB = D_out_mem.
- Priority each edge: reset > flush > stall > normal advance.
- Normal advance (stall=0, flush=0): every *_MEM input is registered into its *_WB counterpart. Latency is 1 cycle. valid_WB <= valid_MEM.
- flush=1: valid_WB, the four flags and WRE_WB go to 0. Data fields are don't-care and are held. hold_valid is cleared. flush overrides a simultaneous stall.
- stall=1 (no flush): all *_WB registers keep their value.
- Load-data hold:
  - On the first stall edge where valid_WB=1 and LW_WB=1, D_out_mem is captured into a hold register and hold_valid is set.
  - D_out_WB = hold_valid ? hold_reg : D_out_mem (combinational mux).
  - hold_valid clears on the first edge with stall=0, i.e. the same edge that advances the pipeline.
  - Consecutive stall cycles do not recapture.
- WRE_WB output = WRE_WB register AND valid_WB.
- retire_count:
  - Increments by 1 on each edge where valid_WB=1 and stall=0, with no flush and no reset.
  - Counts the instruction leaving WB.
  - Wraps modulo 2^CNT_W.
- No combinational path from stall/flush to any *_WB output except through registers. D_out_WB depends combinationally on D_out_mem only when hold_valid=0.

Optional Feature:
WB_BYPASS_EN
- Defined:
  - Adds outputs bypass_valid (1 bit), bypass_reg (REG_AW) and bypass_data (DW).
  - bypass_valid = WRE_WB output.
  - bypass_reg = WReg1_WB.
  - bypass_data is the final writeback value, selected in priority order:
    - ALU_out_WB when ~LW_WB & (ADDI_WB|SUBI_WB).
    - Offset_WB when MOVI_WB & ~LW_WB & ~ADDI_WB.
    - Otherwise D_out_WB.
  - Feeds EX-stage forwarding. Purely combinational from WB registers.
- Undefined: the ports are absent, and no logic is added.

Test Plan:
- Reset: hold reset=1 for 2 cycles with nonzero inputs -> all outputs 0, retire_count=0. Release -> first valid ADDI (ALU_out_MEM=0x5) appears on ALU_out_WB=0x5, ADDI_WB=1, valid_WB=1 one cycle later.
- Load alignment: LW in MEM at cycle N; D_out_mem=0xDEAD_BEEF during cycle N+1 -> D_out_WB=0xDEADBEEF, LW_WB=1, WReg1_WB=destination in cycle N+1.
- Stall on load:
  - Stimulus: stall=1 for 3 cycles after the LW reaches WB, while D_out_mem changes to 0x1234 on the 2nd cycle.
  - Required: D_out_WB stays 0xDEADBEEF throughout; retire_count is unchanged; the release edge increments retire_count by 1.
- Flush + stall simultaneous, valid MOVI in MEM -> next cycle valid_WB=0, WRE_WB=0, MOVI_WB=0, hold_valid=0; retire_count unchanged.
- Counter wrap: CNT_W=4, 17 back-to-back valid instructions -> retire_count reads 1.
- WB_BYPASS_EN: SUBI with ALU_out=0x7 and Offset=0x9 -> bypass_data=0x7. MOVI with Offset=0x9 -> bypass_data=0x9. Bubble -> bypass_valid=0.
